// File: rtl/data_mem_mmio.sv
// Data-side memory for the pipelined core: word RAM plus TX FIFO, STATUS and
// CYCLE registers, all answering loads combinationally in the access cycle.
module data_mem_mmio #(
   parameter int MEM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write,
   input  logic [31:0] data_addr_m,
   input  logic [31:0] write_data_m,
   output logic [31:0] read_data_m,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

   localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
   localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;

   logic [31:0]   mem [MEM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          overflow;
   logic [31:0]   cycle_cnt;

   logic          is_ram, is_txdata, is_status, is_cycle;
   logic [AW-1:0] word_idx;
   logic          full, empty, push_req, push, pop;
   logic [31:0]   status_word;

   assign is_ram    = (data_addr_m[31:28] == 4'h0);
   assign is_txdata = (data_addr_m == ADDR_TXDATA);
   assign is_status = (data_addr_m == ADDR_STATUS);
   assign is_cycle  = (data_addr_m == ADDR_CYCLE);
   assign word_idx  = data_addr_m[AW+1:2];

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
   assign pop      = tx_valid & tx_ready;
   assign push_req = mem_write & is_txdata;
   // A push into a full FIFO survives only when a pop frees the slot this edge.
   assign push     = push_req & (!full | pop);

   assign status_word = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

   always_comb begin
      read_data_m = 32'h0000_0000;
      if (is_ram)
         read_data_m = mem[word_idx];
      else if (is_status)
         read_data_m = status_word;
      else if (is_cycle)
         read_data_m = cycle_cnt;
   end

   // RAM and FIFO storage carry no reset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (mem_write && is_ram)
         mem[word_idx] <= write_data_m;
      if (push && !rst)
         fifo_mem[wr_ptr] <= write_data_m[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         cycle_cnt <= 32'h0000_0000;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);

         if (mem_write && is_status)
            overflow <= 1'b0;
         else if (push_req && !push)
            overflow <= 1'b1;

         if (mem_write && is_cycle)
            cycle_cnt <= write_data_m;
         else
            cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, TX FIFO stream/overflow, STATUS,
// cycle counter and mid-stream reset, checked with immediate assertions.
module tb_data_mem_mmio;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_write;
   logic [31:0] data_addr_m;
   logic [31:0] write_data_m;
   logic [31:0] read_data_m;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int tests  = 0;
   int failed = 0;

   localparam logic [31:0] A_TX  = 32'h8000_0000;
   localparam logic [31:0] A_ST  = 32'h8000_0004;
   localparam logic [31:0] A_CYC = 32'h8000_0008;

   data_mem_mmio #(.MEM_WORDS(1024), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_write    (mem_write),
      .data_addr_m  (data_addr_m),
      .write_data_m (write_data_m),
      .read_data_m  (read_data_m),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      mem_write    = 1'b1;
      data_addr_m  = addr;
      write_data_m = data;
      tick();
      mem_write    = 1'b0;
      data_addr_m  = 32'h0000_0004;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      mem_write   = 1'b0;
      data_addr_m = addr;
      #1;
      chk(tag, read_data_m, exp);
   endtask

   initial begin
      rst = 1'b1; mem_write = 1'b0; data_addr_m = 32'h0; write_data_m = 32'h0; tx_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
      rd("reset_status", A_ST, 32'h0000_0002);

      // cycle counter counts from the reset edge
      rd("cycle_k0", A_CYC, 32'd0);
      tick();
      rd("cycle_k1", A_CYC, 32'd1);
      tick(); tick(); tick();
      rd("cycle_k4", A_CYC, 32'd4);
      wr(A_CYC, 32'hFFFF_FFFE);
      rd("cycle_load", A_CYC, 32'hFFFF_FFFE);
      tick();
      rd("cycle_max", A_CYC, 32'hFFFF_FFFF);
      tick();
      rd("cycle_wrap", A_CYC, 32'h0000_0000);

      // RAM
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      wr(32'h0000_0014, 32'h1234_5678);
      rd("ram_word", 32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_byteoff", 32'h0000_0013, 32'hDEAD_BEEF);
      rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
      rd("ram_next", 32'h0000_0014, 32'h1234_5678);
      rd("unmapped_rd", 32'h8000_0010, 32'h0);
      wr(32'h8000_000C, 32'hFFFF_FFFF);
      rd("unmapped_wr", 32'h8000_000C, 32'h0);
      rd("txdata_rd", A_TX, 32'h0);

      // FIFO stream, no bypass on first push
      mem_write = 1'b1; data_addr_m = A_TX; write_data_m = 32'h0000_0041;
      #1;
      chk("no_bypass_valid", {31'h0, tx_valid}, 32'h0);
      tick();
      mem_write = 1'b0;
      chk("push_valid", {31'h0, tx_valid}, 32'h1);
      wr(A_TX, 32'h0000_0042);
      wr(A_TX, 32'h0000_0043);
      rd("stream_status", A_ST, 32'h0000_0300);
      tx_ready = 1'b1;
      #1;
      chk("stream_b0", {24'h0, tx_data}, 32'h41);
      tick();
      chk("stream_b1", {24'h0, tx_data}, 32'h42);
      tick();
      chk("stream_b2", {24'h0, tx_data}, 32'h43);
      tick();
      chk("stream_done_valid", {31'h0, tx_valid}, 32'h0);
      rd("stream_done_status", A_ST, 32'h0000_0002);
      tx_ready = 1'b0;

      // overflow
      for (int i = 0; i < 9; i++) wr(A_TX, i);
      rd("ovf_status", A_ST, 32'h0000_0805);
      chk("ovf_head", {24'h0, tx_data}, 32'h00);
      wr(A_ST, 32'hFFFF_FFFF);
      rd("ovf_cleared", A_ST, 32'h0000_0801);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf_drain%0d", i), {24'h0, tx_data}, i);
         tick();
      end
      tx_ready = 1'b0;
      chk("ovf_drain_empty", {31'h0, tx_valid}, 32'h0);
      rd("ovf_after_status", A_ST, 32'h0000_0002);

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + i);
      rd("full_status", A_ST, 32'h0000_0801);
      tx_ready = 1'b1;
      wr(A_TX, 32'h0000_0099);
      tx_ready = 1'b0;
      rd("pushpop_status", A_ST, 32'h0000_0801);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("pushpop_drain%0d", i), {24'h0, tx_data},
             (i == 7) ? 32'h99 : 32'h11 + i);
         tick();
      end
      tx_ready = 1'b0;
      chk("pushpop_empty", {31'h0, tx_valid}, 32'h0);

      // reset mid-operation
      for (int i = 0; i < 5; i++) wr(A_TX, 32'hA0 + i);
      wr(A_CYC, 32'd100);
      rd("pre_rst_cycle", A_CYC, 32'd100);
      rd("pre_rst_status", A_ST, 32'h0000_0500);
      tx_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tx_ready = 1'b0;
      #1;
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      rd("rst_status", A_ST, 32'h0000_0002);
      rd("rst_cycle", A_CYC, 32'd0);
      rd("rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
